elevator_request_queue: RTL and testbench
=========================================

Name: elevator_request_queue

Overview:
Holds the car's pending floor requests and selects the next destination for the car controller. It is the write side's counterpart: it consumes the active-low write strobe and floor code from the elevator input panel, latches requests into a per-floor bitmap, and drives button lamps. A direction-collective scheduler (SCAN) presents one registered target floor at a time to the motion controller.

Parameters:
NUM_FLOORS, 7, number of serviced floors; floor codes 0..NUM_FLOORS-1.
FLOOR_W, 3, floor code width; must satisfy 2**FLOOR_W >= NUM_FLOORS.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
r_nwr  in  1  panel strobe; 0 = write requested_floor this cycle, 1 = no write.
requested_floor  in  FLOOR_W  floor code from the input panel.
current_floor  in  FLOOR_W  car position from the motion controller.
arrived  in  1  one-cycle pulse: car has stopped at target_floor.
target_valid  out  1  target_floor holds a valid destination.
target_floor  out  FLOOR_W  next destination.
dir_up  out  1  1 = car committed upward, 0 = downward or idle.
lamps  out  NUM_FLOORS  button illumination; equals the pending bitmap.
pending_count  out  FLOOR_W  number of pending requests (popcount of bitmap).
here_hit  out  1  one-cycle pulse: request for current_floor made while idle.

Behaviour:
- Reset (reset_n=0, async): pending=0, state=IDLE, target_valid=0, target_floor=0, dir_up=0, lamps=0, pending_count=0, here_hit=0.
- Write: on a clk edge with r_nwr=0, set pending[requested_floor]. Codes >= NUM_FLOORS are ignored. A re-press of a pending floor has no effect.
- Idle same-floor press: when state=IDLE and requested_floor==current_floor, pending is not set and here_hit pulses for one cycle.
- Arrival: arrived=1 clears pending[target_floor]. A write to the same floor in the same cycle is dropped, because the car is already there. Writes to other floors in that cycle are accepted.
- lamps and pending_count reflect the registered bitmap; a write is visible 1 cycle after the strobe edge.
- FSM states: IDLE, SERVE_UP, SERVE_DOWN.
  - IDLE -> SERVE_UP if any pending floor > current_floor. Otherwise IDLE -> SERVE_DOWN if any pending floor < current_floor. Otherwise stay in IDLE.
  - SERVE_UP: target = lowest pending floor > current_floor. If none remain (checked on the post-arrival bitmap): go to SERVE_DOWN if any pending floor is below, else IDLE.
  - SERVE_DOWN: the mirror of SERVE_UP; target = highest pending floor < current_floor.
- Outputs per state: dir_up=1 only in SERVE_UP. target_valid=0 in IDLE.
- Target timing: target_floor and target_valid are registered and recomputed every cycle from the next bitmap.
  - A new closer request in the direction of travel retargets 1 cycle after its write.
  - A request behind the car is held until the direction reverses.
- Arrival with an empty bitmap: the FSM returns to IDLE and target_valid drops on the following edge.
- arrived while target_valid=0: ignored.
- Reset mid-operation: all requests are lost and the FSM returns to IDLE immediately.

Decomposition:
- Package elevator_pkg holds:
  - NUM_FLOORS and FLOOR_W defaults.
  - typedef floor_t (logic [FLOOR_W-1:0]).
  - typedef floor_mask_t (logic [NUM_FLOORS-1:0]).
  - enum sched_state_e {IDLE, SERVE_UP, SERVE_DOWN}.
- Sub-module floor_seek (combinational):
  - Inputs: mask and current_floor.
  - Outputs: any_above, nearest_above, any_below, nearest_below.
  - Instantiated once on the next-state bitmap.

Test Plan:
1. Reset, then current_floor=0, write floors 3 and 5 -> lamps=0x28, pending_count=2, SERVE_UP, target_floor=3; after arrived -> lamps=0x20, target_floor=5.
2. current_floor=4 in SERVE_UP toward 6, write floor 5 -> target_floor=5 on the next cycle; write floor 1 -> target unchanged, lamps bit1 set; after 5 and 6 are served -> SERVE_DOWN, target_floor=1, dir_up=0.
3. IDLE at current_floor=2, write floor 2 -> here_hit=1 for one cycle, lamps=0, state stays IDLE.
4. Target 3 pending, arrived=1 and write floor 3 in the same cycle -> lamps bit3=0, pending_count=0, IDLE, target_valid=0.
5. Write requested_floor=7 -> ignored, lamps unchanged. Assert reset_n low mid-SERVE_DOWN -> all outputs 0 asynchronously, with no wait for a clock edge.

Source files
------------

// File: rtl/elevator_request_queue_pkg.sv
// elevator_pkg: shared constants and types for the elevator request queue.
//   DEFAULT_NUM_FLOORS / DEFAULT_FLOOR_W : default floor count and code width.
//   floor_t       : floor code.
//   floor_mask_t  : one bit per floor (pending-request bitmap).
//   sched_state_e : scheduler state (IDLE, SERVE_UP, SERVE_DOWN).
package elevator_pkg;

  localparam int DEFAULT_NUM_FLOORS = 7;
  localparam int DEFAULT_FLOOR_W    = 3;

  typedef logic [DEFAULT_FLOOR_W-1:0]    floor_t;
  typedef logic [DEFAULT_NUM_FLOORS-1:0] floor_mask_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SERVE_UP   = 2'd1,
    SERVE_DOWN = 2'd2
  } sched_state_e;

endpackage

// File: rtl/elevator_request_queue_if.sv
// elevator_request_queue_if: bundles the panel, motion-controller and lamp
// signals of the request queue.
//   slave  : the queue (consumes panel/motion inputs, drives target/lamps).
//   master : the environment (panel + motion controller).
//
// Signalling: there is no valid/ready backpressure. r_nwr is an active-low
// write strobe sampled on every rising clk edge (0 = requested_floor is
// written that edge). arrived is a one-cycle pulse qualified internally by
// target_valid. All outputs are registered; here_hit is a one-cycle pulse.
// dbg_state mirrors the scheduler FSM state for observation.
interface elevator_request_queue_if
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = elevator_pkg::DEFAULT_NUM_FLOORS,
  parameter int FLOOR_W    = elevator_pkg::DEFAULT_FLOOR_W
) ();

  logic                  r_nwr;
  logic [FLOOR_W-1:0]    requested_floor;
  logic [FLOOR_W-1:0]    current_floor;
  logic                  arrived;
  logic                  target_valid;
  logic [FLOOR_W-1:0]    target_floor;
  logic                  dir_up;
  logic [NUM_FLOORS-1:0] lamps;
  logic [FLOOR_W-1:0]    pending_count;
  logic                  here_hit;
  sched_state_e          dbg_state;

  modport slave (
    input  r_nwr, requested_floor, current_floor, arrived,
    output target_valid, target_floor, dir_up, lamps, pending_count,
           here_hit, dbg_state
  );

  modport master (
    output r_nwr, requested_floor, current_floor, arrived,
    input  target_valid, target_floor, dir_up, lamps, pending_count,
           here_hit, dbg_state
  );

endinterface

// File: rtl/elevator_request_queue_floor_seek.sv
// floor_seek: combinational search of a floor bitmap relative to the car.
//   mask          : pending-request bitmap.
//   current_floor : car position.
//   any_above / nearest_above : a pending floor exists above; lowest such floor.
//   any_below / nearest_below : a pending floor exists below; highest such floor.
// The nearest_* outputs are 0 when the matching any_* is 0.
module floor_seek
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = elevator_pkg::DEFAULT_NUM_FLOORS,
  parameter int FLOOR_W    = elevator_pkg::DEFAULT_FLOOR_W
) (
  input  logic [NUM_FLOORS-1:0] mask,
  input  logic [FLOOR_W-1:0]    current_floor,
  output logic                  any_above,
  output logic [FLOOR_W-1:0]    nearest_above,
  output logic                  any_below,
  output logic [FLOOR_W-1:0]    nearest_below
);

  always_comb begin
    any_above     = 1'b0;
    nearest_above = '0;
    any_below     = 1'b0;
    nearest_below = '0;
    // Walk from the top down so the last hit above the car is the lowest one.
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(current_floor))) begin
        any_above     = 1'b1;
        nearest_above = FLOOR_W'(i);
      end
    end
    // Walk from the bottom up so the last hit below the car is the highest one.
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (mask[i] && (i < int'(current_floor))) begin
        any_below     = 1'b1;
        nearest_below = FLOOR_W'(i);
      end
    end
  end

endmodule

// File: rtl/elevator_request_queue.sv
// elevator_request_queue: latches floor requests from the input panel into a
// per-floor bitmap, drives the button lamps and schedules the car with a
// direction-collective (SCAN) policy, presenting one registered target.
//   clk     : system clock, rising edge.
//   reset_n : asynchronous active-low reset.
//   bus     : elevator_request_queue_if.slave (panel strobe/floor, car
//             position, arrival pulse, target/direction, lamps, pending
//             count, here_hit pulse, debug state).
module elevator_request_queue
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = elevator_pkg::DEFAULT_NUM_FLOORS,
  parameter int FLOOR_W    = elevator_pkg::DEFAULT_FLOOR_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  elevator_request_queue_if.slave  bus
);

  logic [NUM_FLOORS-1:0] pending;
  logic [NUM_FLOORS-1:0] pending_nx;
  logic [FLOOR_W-1:0]    count_q;
  logic [FLOOR_W-1:0]    count_nx;
  sched_state_e          state;
  logic                  valid_q;
  logic [FLOOR_W-1:0]    target_q;
  logic                  dir_up_q;
  logic                  here_q;
  logic                  here_nx;

  logic                  write_ok;
  logic                  arrive_now;
  logic                  any_above;
  logic                  any_below;
  logic [FLOOR_W-1:0]    nearest_above;
  logic [FLOOR_W-1:0]    nearest_below;

  // Out-of-range floor codes never reach the bitmap.
  assign write_ok   = !bus.r_nwr && (int'(bus.requested_floor) < NUM_FLOORS);
  // An arrival only means something while a target is actually presented.
  assign arrive_now = bus.arrived && valid_q;

  always_comb begin
    pending_nx = pending;
    here_nx    = 1'b0;
    if (arrive_now) begin
      pending_nx[target_q] = 1'b0;
    end
    if (write_ok) begin
      if ((state == IDLE) && (bus.requested_floor == bus.current_floor)) begin
        // Car is parked at the pressed floor: nothing to schedule.
        here_nx = 1'b1;
      end else if (!(arrive_now && (bus.requested_floor == target_q))) begin
        // A press for the floor being arrived at this cycle is already served.
        pending_nx[bus.requested_floor] = 1'b1;
      end
    end
  end

  always_comb begin
    count_nx = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      count_nx = count_nx + FLOOR_W'(pending_nx[i]);
    end
  end

  // Seek runs on the next bitmap so targets react one cycle after a write
  // and an arrival is reflected on the same edge that clears its bit.
  floor_seek #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_floor_seek (
    .mask          (pending_nx),
    .current_floor (bus.current_floor),
    .any_above     (any_above),
    .nearest_above (nearest_above),
    .any_below     (any_below),
    .nearest_below (nearest_below)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending  <= '0;
      count_q  <= '0;
      state    <= IDLE;
      valid_q  <= 1'b0;
      target_q <= '0;
      dir_up_q <= 1'b0;
      here_q   <= 1'b0;
    end else begin
      pending <= pending_nx;
      count_q <= count_nx;
      here_q  <= here_nx;
      unique case (state)
        SERVE_DOWN: begin
          // Keep going down while anything is below; requests above wait.
          if (any_below) begin
            state    <= SERVE_DOWN;
            valid_q  <= 1'b1;
            target_q <= nearest_below;
            dir_up_q <= 1'b0;
          end else if (any_above) begin
            state    <= SERVE_UP;
            valid_q  <= 1'b1;
            target_q <= nearest_above;
            dir_up_q <= 1'b1;
          end else begin
            state    <= IDLE;
            valid_q  <= 1'b0;
            target_q <= '0;
            dir_up_q <= 1'b0;
          end
        end
        default: begin
          // IDLE and SERVE_UP both prefer upward work first.
          if (any_above) begin
            state    <= SERVE_UP;
            valid_q  <= 1'b1;
            target_q <= nearest_above;
            dir_up_q <= 1'b1;
          end else if (any_below) begin
            state    <= SERVE_DOWN;
            valid_q  <= 1'b1;
            target_q <= nearest_below;
            dir_up_q <= 1'b0;
          end else begin
            state    <= IDLE;
            valid_q  <= 1'b0;
            target_q <= '0;
            dir_up_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.target_valid  = valid_q;
  assign bus.target_floor  = target_q;
  assign bus.dir_up        = dir_up_q;
  assign bus.lamps         = pending;
  assign bus.pending_count = count_q;
  assign bus.here_hit      = here_q;
  assign bus.dbg_state     = state;

endmodule

// File: tb/tb_elevator_request_queue.sv
// Directed bench for elevator_request_queue: a table of per-cycle input
// records with hand-computed expected outputs, followed by a hand-written
// asynchronous-reset sequence.
module tb_elevator_request_queue;
  import elevator_pkg::*;

  localparam int NF = DEFAULT_NUM_FLOORS;
  localparam int FW = DEFAULT_FLOOR_W;

  logic clk;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  elevator_request_queue_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) bus ();

  elevator_request_queue #(.NUM_FLOORS(NF), .FLOOR_W(FW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic         rst_n;
    logic         nwr;
    int           req;
    int           cur;
    logic         arr;
    int           lamps;
    int           cnt;
    logic         valid;
    int           tgt;
    logic         dir;
    logic         here;
    sched_state_e st;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst_n, input logic nwr, input int req,
                     input int cur, input logic arr, input int lamps,
                     input int cnt, input logic valid, input int tgt,
                     input logic dir, input logic here, input sched_state_e st);
    vec_t v;
    v.rst_n = rst_n; v.nwr = nwr; v.req = req; v.cur = cur; v.arr = arr;
    v.lamps = lamps; v.cnt = cnt; v.valid = valid; v.tgt = tgt;
    v.dir = dir; v.here = here; v.st = st;
    vecs.push_back(v);
  endtask

  // ---------------- driver / checker ----------------
  task automatic drive(input vec_t v);
    reset_n             = v.rst_n;
    bus.r_nwr           = v.nwr;
    bus.requested_floor = FW'(v.req);
    bus.current_floor   = FW'(v.cur);
    bus.arrived         = v.arr;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input int lamps, input int cnt,
                             input logic valid, input int tgt, input logic dir,
                             input logic here, input sched_state_e st);
    chk({tag, " lamps"},         int'(bus.lamps),         lamps);
    chk({tag, " pending_count"}, int'(bus.pending_count), cnt);
    chk({tag, " target_valid"},  int'(bus.target_valid),  int'(valid));
    chk({tag, " target_floor"},  int'(bus.target_floor),  tgt);
    chk({tag, " dir_up"},        int'(bus.dir_up),        int'(dir));
    chk({tag, " here_hit"},      int'(bus.here_hit),      int'(here));
    chk({tag, " state"},         int'(bus.dbg_state),     int'(st));
  endtask

  initial begin
    reset_n             = 1'b0;
    bus.r_nwr           = 1'b1;
    bus.requested_floor = '0;
    bus.current_floor   = '0;
    bus.arrived         = 1'b0;

    //  rst nwr req cur arr | lamps cnt vld tgt dir here state
    // Two requests above, then serve the first.
    add(0, 1, 0, 0, 0,  'h00, 0, 0, 0, 0, 0, IDLE);
    add(1, 0, 3, 0, 0,  'h08, 1, 1, 3, 1, 0, SERVE_UP);
    add(1, 0, 5, 0, 0,  'h28, 2, 1, 3, 1, 0, SERVE_UP);
    add(1, 1, 0, 0, 1,  'h20, 1, 1, 5, 1, 0, SERVE_UP);
    // Closer request retargets; request behind is held until reversal.
    add(0, 1, 0, 4, 0,  'h00, 0, 0, 0, 0, 0, IDLE);
    add(1, 0, 6, 4, 0,  'h40, 1, 1, 6, 1, 0, SERVE_UP);
    add(1, 0, 5, 4, 0,  'h60, 2, 1, 5, 1, 0, SERVE_UP);
    add(1, 0, 1, 4, 0,  'h62, 3, 1, 5, 1, 0, SERVE_UP);
    add(1, 1, 0, 5, 1,  'h42, 2, 1, 6, 1, 0, SERVE_UP);
    add(1, 1, 0, 6, 1,  'h02, 1, 1, 1, 0, 0, SERVE_DOWN);
    // Same-floor press while idle: one-cycle here_hit, nothing latched.
    add(0, 1, 0, 2, 0,  'h00, 0, 0, 0, 0, 0, IDLE);
    add(1, 0, 2, 2, 0,  'h00, 0, 0, 0, 0, 1, IDLE);
    add(1, 1, 0, 2, 0,  'h00, 0, 0, 0, 0, 0, IDLE);
    // Arrival and press of the target floor in the same cycle.
    add(1, 0, 3, 0, 0,  'h08, 1, 1, 3, 1, 0, SERVE_UP);
    add(1, 0, 3, 0, 1,  'h00, 0, 0, 0, 0, 0, IDLE);
    // arrived while no target is presented is ignored.
    add(1, 1, 0, 0, 1,  'h00, 0, 0, 0, 0, 0, IDLE);
    // Out-of-range code, re-press, and a request behind the car.
    add(1, 0, 5, 3, 0,  'h20, 1, 1, 5, 1, 0, SERVE_UP);
    add(1, 0, 7, 3, 0,  'h20, 1, 1, 5, 1, 0, SERVE_UP);
    add(1, 0, 1, 3, 0,  'h22, 2, 1, 5, 1, 0, SERVE_UP);
    add(1, 0, 5, 3, 0,  'h22, 2, 1, 5, 1, 0, SERVE_UP);
    // Serve 5 while a request at 6 arrives; then reverse toward 1.
    add(1, 0, 6, 5, 1,  'h42, 2, 1, 6, 1, 0, SERVE_UP);
    add(1, 1, 0, 6, 1,  'h02, 1, 1, 1, 0, 0, SERVE_DOWN);
    // Request above while heading down is held.
    add(1, 0, 4, 3, 0,  'h12, 2, 1, 1, 0, 0, SERVE_DOWN);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      chk_outputs($sformatf("vec%0d", i), vecs[i].lamps, vecs[i].cnt,
                  vecs[i].valid, vecs[i].tgt, vecs[i].dir, vecs[i].here,
                  vecs[i].st);
    end

    // Asynchronous reset mid-SERVE_DOWN: outputs must clear before any edge.
    @(negedge clk);
    bus.r_nwr   = 1'b1;
    bus.arrived = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk_outputs("async_reset", 'h00, 0, 0, 0, 0, 0, IDLE);

    // Held in reset across an edge, with a write attempt, stays cleared.
    bus.r_nwr           = 1'b0;
    bus.requested_floor = FW'(6);
    @(posedge clk);
    #1;
    chk_outputs("reset_hold", 'h00, 0, 0, 0, 0, 0, IDLE);

    // Release and confirm operation resumes from an empty queue.
    @(negedge clk);
    reset_n             = 1'b1;
    bus.r_nwr           = 1'b0;
    bus.requested_floor = FW'(0);
    bus.current_floor   = FW'(3);
    @(posedge clk);
    #1;
    chk_outputs("post_reset", 'h01, 1, 1, 0, 0, 0, SERVE_DOWN);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
